// File: rtl/uart_receiver.sv
// Purpose  : 8N1 UART receiver with 16x oversampling, held valid/ack byte output, framing/overrun flags.
// Latency  : rx_valid rises 3 + (OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE)*TICK_DIV + 1 clks after the start-bit edge.
// Backpress: one-byte holding register; a byte completing while rx_valid is held (no ack) is dropped and sets overrun.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous, active-low
//   rx_in     - asynchronous serial line, idle high
//   d_out     - received byte, meaningful while rx_valid=1
//   rx_valid  - byte available, held until rx_ack
//   rx_ack    - consumer accepts d_out (pulse or level)
//   rx_busy   - receiver is inside a frame (FSM not idle)
//   frame_err - sticky: last frame had a low stop bit
//   overrun   - sticky: a completed byte was dropped because rx_valid was still set
module uart_receiver #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OS_W     = $clog2(OVERSAMPLE);
    localparam int IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] d_out_q, d_out_d;
    logic                 deliver_q, deliver_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    // Two-flop synchronizer plus one previous-sample flop for edge detect.
    logic rx_meta_q, rx_s_q, rx_prev_q;

    logic tick;
    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        os_cnt_d    = os_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        d_out_d     = d_out_q;
        deliver_d   = 1'b0;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        if (state_q != ST_IDLE) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
            if (tick) begin
                os_cnt_d = os_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                os_cnt_d   = '0;
                bit_idx_d  = '0;
                // Only a 1->0 transition starts a frame; a stuck-low line does not.
                if (rx_prev_q && !rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick && os_cnt_q == OS_MID) begin
                    os_cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick && os_cnt_q == OS_LAST) begin
                    os_cnt_d           = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick && os_cnt_q == OS_LAST) begin
                    os_cnt_d = '0;
                    // Returning to idle at mid stop bit lets a start bit that
                    // immediately follows the stop bit be caught.
                    state_d  = ST_IDLE;
                    if (rx_s_q) begin
                        deliver_d   = 1'b1;
                        frame_err_d = 1'b0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Delivery is resolved one cycle after the stop sample. An ack in that
        // same cycle frees the holding register, so the new byte replaces it.
        if (deliver_q) begin
            if (!rx_valid_q || rx_ack) begin
                d_out_d    = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            d_out_q     <= '0;
            deliver_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            d_out_q     <= d_out_d;
            deliver_q   <= deliver_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_meta_q   <= rx_in;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
        end
    end

    assign d_out     = d_out_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = (state_q != ST_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Purpose  : directed bench for uart_receiver; expected bytes queued by stimulus, popped by a monitor.
// Latency  : n/a (bench).
// Backpress: bench drives rx_ack explicitly per scenario.
module tb_uart_receiver;

    localparam int BIT_CLKS  = 864;
    localparam int FAST_CLKS = 839;   // 864/1.03, sender 3% fast
    localparam int STOP_LAT  = 8211;  // 3 (sync+edge) + 8208 to stop sample

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic [7:0] d_out;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] exp_q[$];
    logic       busy_seen = 1'b0;
    logic       pv = 1'b0;
    logic       pa = 1'b0;

    always #5 clk = ~clk;

    uart_receiver dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .d_out     (d_out),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives the first nbits line bits of an 8N1 frame; called just after a posedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int bit_clks, input int nbits);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_in = fr[i];
            repeat (bit_clks) @(posedge clk);
            #1;
        end
        rx_in = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: a new byte is presented when rx_valid is seen high and either it
    // was low at the previous sample or an ack was taken at the edge between.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rx_busy === 1'b1) busy_seen = 1'b1;
            if (rx_valid === 1'b1 && (!pv || pa)) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_unexpected: got byte %h, expected no byte", d_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", d_out, e);
                end
            end
            pv = (rx_valid === 1'b1);
            pa = (rx_ack === 1'b1);
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        rx_in  = 1'b1;
        rx_ack = 1'b0;
        idle(3);
        chk("rst_d_out",     d_out,         8'h00);
        chk("rst_rx_valid",  8'(rx_valid),  8'h0);
        chk("rst_rx_busy",   8'(rx_busy),   8'h0);
        chk("rst_frame_err", 8'(frame_err), 8'h0);
        chk("rst_overrun",   8'(overrun),   8'h0);
        reset = 1'b1;
        idle(10);

        // 1. Basic byte plus exact delivery latency.
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, BIT_CLKS, 10);
            begin
                repeat (STOP_LAT) @(posedge clk);
                #1;
                chk("t1_valid_before", 8'(rx_valid), 8'h0);
                @(posedge clk);
                #1;
                chk("t1_valid_rise", 8'(rx_valid), 8'h1);
            end
        join
        chk("t1_d_out",     d_out,         8'hA5);
        chk("t1_frame_err", 8'(frame_err), 8'h0);
        chk("t1_overrun",   8'(overrun),   8'h0);
        ack_pulse();
        chk("t1_ack_clears", 8'(rx_valid), 8'h0);
        idle(20);

        // 2. 200-clk low glitch is rejected at mid start bit.
        busy_seen = 1'b0;
        rx_in = 1'b0;
        idle(200);
        rx_in = 1'b1;
        idle(600);
        chk("t2_busy_pulsed", 8'(busy_seen), 8'h1);
        chk("t2_busy_low",    8'(rx_busy),   8'h0);
        chk("t2_valid",       8'(rx_valid),  8'h0);
        chk("t2_frame_err",   8'(frame_err), 8'h0);
        chk("t2_overrun",     8'(overrun),   8'h0);

        // 3. Bad stop bit, then a good frame clears frame_err.
        send_frame(8'h3C, 1'b0, BIT_CLKS, 10);
        idle(20);
        chk("t3_frame_err_set", 8'(frame_err), 8'h1);
        chk("t3_valid_low",     8'(rx_valid),  8'h0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, BIT_CLKS, 10);
        chk("t3_d_out",          d_out,         8'h55);
        chk("t3_valid",          8'(rx_valid),  8'h1);
        chk("t3_frame_err_clr",  8'(frame_err), 8'h0);
        ack_pulse();
        idle(20);

        // 4. Back-to-back, no ack: second byte dropped.
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1, BIT_CLKS, 10);
        send_frame(8'hCC, 1'b1, BIT_CLKS, 10);
        chk("t4_d_out_held", d_out,       8'hAA);
        chk("t4_overrun",    8'(overrun), 8'h1);
        chk("t4_valid",      8'(rx_valid), 8'h1);
        ack_pulse();
        chk("t4_ack_valid",   8'(rx_valid), 8'h0);
        chk("t4_ack_overrun", 8'(overrun),  8'h0);
        idle(20);

        // 5. Ack lands exactly in the delivery cycle of the next byte.
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1, BIT_CLKS, 10);
        exp_q.push_back(8'hCC);
        fork
            send_frame(8'hCC, 1'b1, BIT_CLKS, 10);
            begin
                repeat (STOP_LAT) @(posedge clk);
                #1;
                rx_ack = 1'b1;
                @(posedge clk);
                #1;
                rx_ack = 1'b0;
            end
        join
        chk("t5_d_out",   d_out,        8'hCC);
        chk("t5_valid",   8'(rx_valid), 8'h1);
        chk("t5_overrun", 8'(overrun),  8'h0);

        // 6. Reset mid-DATA (rx_valid still held), then a 3%-fast frame.
        send_frame(8'h0F, 1'b1, BIT_CLKS, 4);
        chk("t6_busy_mid", 8'(rx_busy), 8'h1);
        reset = 1'b0;
        rx_in = 1'b1;
        idle(2);
        chk("t6_rst_d_out",     d_out,         8'h00);
        chk("t6_rst_valid",     8'(rx_valid),  8'h0);
        chk("t6_rst_busy",      8'(rx_busy),   8'h0);
        chk("t6_rst_frame_err", 8'(frame_err), 8'h0);
        chk("t6_rst_overrun",   8'(overrun),   8'h0);
        reset = 1'b1;
        idle(50);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, FAST_CLKS, 10);
        idle(20);
        chk("t6_d_out",     d_out,         8'hF0);
        chk("t6_valid",     8'(rx_valid),  8'h1);
        chk("t6_frame_err", 8'(frame_err), 8'h0);

        chk("sb_drained", 8'(exp_q.size()), 8'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
